axil_wr_pair_slice: RTL and testbench
=====================================

// Module: axil_wr_pair_slice
// PURPOSE
// AXI4-Lite register slice between the CPU/BFM master and axi2simple_bridge.
// Buffers AW, W and AR independently, so the master may issue AW and W in any order or cycle.
// Presents AW+W to the bridge only as a joint pair, matching the bridge's accept-only-when-both rule.
// Tracks outstanding transactions, enforces per-direction limits, and flags spurious B/R responses.
// PARAMETERS
// MAX_WR  default 2  max writes accepted on s_AW but not yet B-handshaken upstream (1..15)
// MAX_RD  default 2  max reads accepted on s_AR but not yet R-handshaken upstream (1..15)
// PORTS
// clk               in   1   clock
// rst               in   1   synchronous reset, active-high
// s_awvalid/ready   in/out 1 upstream write-address handshake; s_awaddr in 32
// s_wvalid/ready    in/out 1 upstream write-data handshake; s_wdata in 32; s_wstrb in 4
// s_bvalid/ready    out/in 1 upstream write response; s_bresp out 2
// s_arvalid/ready   in/out 1 upstream read-address handshake; s_araddr in 32
// s_rvalid/ready    out/in 1 upstream read data; s_rdata out 32; s_rresp out 2
// m_aw*/m_w*/m_b*/m_ar*/m_r*  downstream mirror of the s_* set, to the bridge slave port
// wr_outstanding    out  4   current write count
// rd_outstanding    out  4   current read count
// err_spurious      out  1   sticky: B or R seen downstream while the matching count == 0
// BEHAVIOUR
// Reset (sync, rst=1 at posedge): all buffers empty, counts 0, err_spurious 0.
//  - All m_*valid and s_*ready outputs are 0 while rst=1.
//  - Reset mid-transaction drops all buffered AW/W/AR; no response is generated for them.
// AW, W, AR buffers: one entry each.
//  - s_awready = !aw_full && wr_cnt != MAX_WR.
//  - s_wready  = !w_full.
//  - s_arready = !ar_full && rd_cnt != MAX_RD.
//  - An entry loads on valid&&ready and clears when its downstream handshake completes.
//  - An entry cannot reload in the same cycle it clears; throughput is one transaction per 2 cycles minimum.
// Write pairing (aw_done/w_done flags):
//  - m_awvalid = aw_full && w_full && !aw_done.
//  - m_wvalid  = aw_full && w_full && !w_done.
//  - If only one downstream ready fires, set its done flag and hold the other valid until its ready.
//  - Both entries and both flags clear in the cycle the second handshake completes.
//  - Valid never drops before its ready fires (AXI rule).
// Read path: m_arvalid = ar_full; the entry clears on m_arready.
// Latency: AW+W or AR captured at posedge N; m_*valid goes high in cycle N+1. Adds 1 cycle per request.
// B/R channels: combinational pass-through, e.g. s_bvalid=m_bvalid, m_bready=s_bready; same for R, resp, rdata.
// Counters:
//  - wr_cnt: +1 on s_AW handshake, -1 on s_B handshake.
//  - rd_cnt: +1 on s_AR handshake, -1 on s_R handshake.
//  - Simultaneous +1/-1 leaves the count unchanged.
//  - A decrement at 0 does not wrap; it sets err_spurious instead.
// Ordering: no write/read reordering is added. The bridge's write-priority rule decides arbitration.
// STRUCTURE
// Shared package snn_axil_pkg:
//  - AXIL_ADDR_W=32, AXIL_DATA_W=32.
//  - Response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
//  - Typedefs axil_aw_t {addr}, axil_w_t {data, strb}.
// Sub-module axil_hold_reg #(type T): one-entry valid+payload register.
//  - Ports: clk, rst, in_valid, in_ready, in_data, out_valid, out_clear, out_data.
//  - Instantiated three times: AW, W, AR.
// Pairing flags, counters and err logic live in the top module.
// TESTING
// 1. AW and W same cycle, addr 0x4000_0010, data 0xDEAD_BEEF, strb 0xF
//    -> one cycle later m_awvalid=m_wvalid=1 with the same values; B OKAY returned upstream.
// 2. W at cycle 0 (data 0x1234_5678), AW at cycle 3 (addr 0x10)
//    -> s_wready=0 during cycles 1-3; m_aw/m_wvalid first high at cycle 4; exactly one downstream write.
// 3. Downstream m_awready=1, m_wready=0 for 2 cycles
//    -> m_awvalid drops after its handshake; m_wvalid stays 1 until ready; buffers clear only then.
// 4. Issue 3 AW+W with s_bready=0 and MAX_WR=2
//    -> third s_awready=0, wr_outstanding=2; after one B handshake, the third is accepted.
// 5. Inject m_rvalid with rd_cnt=0
//    -> err_spurious=1 next cycle, rd_outstanding stays 0; cleared only by rst.
// 6. Assert rst while AW buffered and AR pending
//    -> next cycle all valids/readies 0, counts 0; after release, a read of 0x0 completes normally.

Source files
------------

// File: rtl/snn_axil_pkg.sv
// Shared AXI4-Lite widths, response codes and channel payload types.
package snn_axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
  } axil_aw_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } axil_w_t;

  // Read address carries the same payload as write address.
  typedef axil_aw_t axil_ar_t;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid+payload holding register. Accepts only while empty, so an
// entry can never reload in the cycle it is cleared.
module axil_hold_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_clear,
  output T     out_data
);

  logic full_q, full_d;
  T     data_q, data_d;

  // Nothing is offered in either direction while reset is held.
  assign in_ready  = !full_q && !rst;
  assign out_valid = full_q && !rst;
  assign out_data  = data_q;

  // Next-state: clear on downstream completion, load on upstream handshake.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (out_clear)
      full_d = 1'b0;
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Entry state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axil_wr_pair_slice.sv
// AXI4-Lite register slice: independent AW/W/AR buffers, joint AW+W
// presentation downstream, outstanding-transaction limits, and a sticky flag
// for responses that arrive with nothing outstanding.
module axil_wr_pair_slice
  import snn_axil_pkg::*;
#(
  parameter int MAX_WR = 2,
  parameter int MAX_RD = 2
) (
  input  logic        clk,
  input  logic        rst,
  // upstream
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  // downstream
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  // status
  output logic [3:0]  wr_outstanding,
  output logic [3:0]  rd_outstanding,
  output logic        err_spurious
);

  localparam logic [3:0] MAX_WR_C = 4'(MAX_WR);
  localparam logic [3:0] MAX_RD_C = 4'(MAX_RD);

  logic [3:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic       err_q, err_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic       wr_room, rd_room;
  logic       aw_in_rdy, w_in_rdy, ar_in_rdy;
  logic       aw_full, w_full, ar_full;
  logic       aw_hs, w_hs, pair_done, ar_hs;
  logic       wr_inc, wr_dec, rd_inc, rd_dec;
  axil_aw_t   aw_in, aw_out;
  axil_w_t    w_in, w_out;
  axil_ar_t   ar_in, ar_out;

  assign wr_room = (wr_cnt_q != MAX_WR_C);
  assign rd_room = (rd_cnt_q != MAX_RD_C);

  assign aw_in = '{addr: s_awaddr};
  assign w_in  = '{data: s_wdata, strb: s_wstrb};
  assign ar_in = '{addr: s_araddr};

  // The outstanding limit gates the AW/AR handshake on top of buffer space.
  assign s_awready = aw_in_rdy && wr_room;
  assign s_arready = ar_in_rdy && rd_room;

  axil_hold_reg #(.T(axil_aw_t)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(s_awvalid && wr_room), .in_ready(aw_in_rdy), .in_data(aw_in),
    .out_valid(aw_full), .out_clear(pair_done), .out_data(aw_out)
  );

  axil_hold_reg #(.T(axil_w_t)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(s_wvalid), .in_ready(w_in_rdy), .in_data(w_in),
    .out_valid(w_full), .out_clear(pair_done), .out_data(w_out)
  );

  axil_hold_reg #(.T(axil_ar_t)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(s_arvalid && rd_room), .in_ready(ar_in_rdy), .in_data(ar_in),
    .out_valid(ar_full), .out_clear(ar_hs), .out_data(ar_out)
  );

  assign s_wready = w_in_rdy;

  // Write is offered downstream only as a pair; each side drops once taken.
  assign m_awvalid = aw_full && w_full && !aw_done_q;
  assign m_wvalid  = aw_full && w_full && !w_done_q;
  assign m_awaddr  = aw_out.addr;
  assign m_wdata   = w_out.data;
  assign m_wstrb   = w_out.strb;

  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;
  assign pair_done = (aw_hs || aw_done_q) && (w_hs || w_done_q);

  assign m_arvalid = ar_full;
  assign m_araddr  = ar_out.addr;
  assign ar_hs     = m_arvalid && m_arready;

  // Responses pass straight through.
  assign s_bvalid = m_bvalid;
  assign m_bready = s_bready;
  assign s_bresp  = m_bresp;
  assign s_rvalid = m_rvalid;
  assign m_rready = s_rready;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;

  assign wr_inc = s_awvalid && s_awready;
  assign wr_dec = s_bvalid && s_bready;
  assign rd_inc = s_arvalid && s_arready;
  assign rd_dec = s_rvalid && s_rready;

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign err_spurious   = err_q;

  // Pairing flags, saturating-at-zero counters and sticky spurious-response flag.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (pair_done) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs)  w_done_d  = 1'b1;
    end

    // A decrement at zero is dropped rather than wrapping.
    wr_cnt_d = wr_cnt_q + 4'(wr_inc) - 4'(wr_dec && (wr_cnt_q != 4'd0));
    rd_cnt_d = rd_cnt_q + 4'(rd_inc) - 4'(rd_dec && (rd_cnt_q != 4'd0));

    err_d = err_q;
    if ((m_bvalid && wr_cnt_q == 4'd0) || (m_rvalid && rd_cnt_q == 4'd0))
      err_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_cnt_q  <= 4'd0;
      rd_cnt_q  <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axil_wr_pair_slice.sv
// Directed bench for axil_wr_pair_slice: inputs are driven and outputs
// sampled around the falling edge, the DUT clocks on the rising edge.
module tb_axil_wr_pair_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [3:0]  wr_outstanding, rd_outstanding;
  logic        err_spurious;

  int total = 0;
  int bad   = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  int aw_base, w_base;

  always #5 clk = ~clk;

  axil_wr_pair_slice #(.MAX_WR(2), .MAX_RD(2)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .err_spurious(err_spurious)
  );

  // Count downstream write handshakes.
  always @(posedge clk) begin
    if (m_awvalid && m_awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (m_wvalid && m_wready)   w_hs_cnt  <= w_hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
    s_bready = 0; s_arvalid = 0; s_araddr = 0; s_rready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    repeat (3) cyc();
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    rst = 1'b0;
    #1;
    chk("rst_wr_cnt", wr_outstanding, 0);
    chk("rst_rd_cnt", rd_outstanding, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_awready_rel", s_awready, 1);
    chk("rst_m_awvalid", m_awvalid, 0);

    // 1: AW and W together
    cyc();
    s_awvalid = 1; s_awaddr = 32'h4000_0010;
    s_wvalid = 1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
    #1;
    chk("t1_wready", s_wready, 1);
    chk("t1_m_awvalid_pre", m_awvalid, 0);
    cyc();
    s_awvalid = 0; s_wvalid = 0;
    chk("t1_m_awvalid", m_awvalid, 1);
    chk("t1_m_wvalid", m_wvalid, 1);
    chk("t1_awaddr", m_awaddr, 32'h4000_0010);
    chk("t1_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("t1_wstrb", m_wstrb, 4'hF);
    chk("t1_wr_cnt", wr_outstanding, 1);
    chk("t1_awready_full", s_awready, 0);
    m_awready = 1; m_wready = 1;
    cyc();
    m_awready = 0; m_wready = 0;
    chk("t1_m_awvalid_done", m_awvalid, 0);
    chk("t1_m_wvalid_done", m_wvalid, 0);
    chk("t1_awready_free", s_awready, 1);
    m_bvalid = 1; m_bresp = 2'b00; s_bready = 1;
    #1;
    chk("t1_s_bvalid", s_bvalid, 1);
    chk("t1_s_bresp", s_bresp, 0);
    chk("t1_m_bready", m_bready, 1);
    cyc();
    m_bvalid = 0; s_bready = 0;
    chk("t1_wr_cnt_end", wr_outstanding, 0);
    chk("t1_err", err_spurious, 0);

    // 2: W first, AW three cycles later
    aw_base = aw_hs_cnt; w_base = w_hs_cnt;
    s_wvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
    cyc();
    s_wvalid = 0;
    chk("t2_wready_c1", s_wready, 0);
    chk("t2_m_wvalid_c1", m_wvalid, 0);
    cyc();
    chk("t2_wready_c2", s_wready, 0);
    chk("t2_m_awvalid_c2", m_awvalid, 0);
    cyc();
    s_awvalid = 1; s_awaddr = 32'h0000_0010;
    #1;
    chk("t2_wready_c3", s_wready, 0);
    chk("t2_m_wvalid_c3", m_wvalid, 0);
    cyc();
    s_awvalid = 0;
    chk("t2_m_awvalid_c4", m_awvalid, 1);
    chk("t2_m_wvalid_c4", m_wvalid, 1);
    chk("t2_awaddr", m_awaddr, 32'h10);
    chk("t2_wdata", m_wdata, 32'h1234_5678);
    m_awready = 1; m_wready = 1;
    cyc();
    m_awready = 0; m_wready = 0;
    chk("t2_m_awvalid_c5", m_awvalid, 0);
    repeat (2) cyc();
    chk("t2_aw_count", aw_hs_cnt - aw_base, 1);
    chk("t2_w_count", w_hs_cnt - w_base, 1);
    m_bvalid = 1; s_bready = 1;
    cyc();
    m_bvalid = 0; s_bready = 0;
    chk("t2_wr_cnt_end", wr_outstanding, 0);

    // 3: AW taken first, W held two cycles
    s_awvalid = 1; s_awaddr = 32'h20;
    s_wvalid = 1; s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'h3;
    cyc();
    s_awvalid = 0; s_wvalid = 0;
    chk("t3_m_awvalid", m_awvalid, 1);
    chk("t3_m_wvalid", m_wvalid, 1);
    m_awready = 1;
    cyc();
    m_awready = 0;
    chk("t3_awvalid_drop", m_awvalid, 0);
    chk("t3_wvalid_hold1", m_wvalid, 1);
    chk("t3_awready_busy", s_awready, 0);
    cyc();
    chk("t3_awvalid_low2", m_awvalid, 0);
    chk("t3_wvalid_hold2", m_wvalid, 1);
    chk("t3_wstrb", m_wstrb, 4'h3);
    m_wready = 1;
    cyc();
    m_wready = 0;
    chk("t3_wvalid_done", m_wvalid, 0);
    chk("t3_awready_free", s_awready, 1);
    chk("t3_wready_free", s_wready, 1);
    m_bvalid = 1; s_bready = 1;
    cyc();
    m_bvalid = 0; s_bready = 0;
    chk("t3_wr_cnt_end", wr_outstanding, 0);

    // 4: outstanding-write limit
    m_awready = 1; m_wready = 1;
    s_awvalid = 1; s_awaddr = 32'h100; s_wvalid = 1; s_wdata = 32'h1; s_wstrb = 4'hF;
    cyc();
    s_awvalid = 0; s_wvalid = 0;
    cyc();
    s_awvalid = 1; s_awaddr = 32'h104; s_wvalid = 1; s_wdata = 32'h2;
    cyc();
    s_awvalid = 0; s_wvalid = 0;
    cyc();
    s_awvalid = 1; s_awaddr = 32'h108; s_wvalid = 1; s_wdata = 32'h3;
    #1;
    chk("t4_wr_cnt_full", wr_outstanding, 2);
    chk("t4_awready_limit", s_awready, 0);
    cyc();
    s_wvalid = 0;
    chk("t4_awready_limit2", s_awready, 0);
    chk("t4_m_awvalid_idle", m_awvalid, 0);
    m_bvalid = 1; s_bready = 1;
    cyc();
    m_bvalid = 0; s_bready = 0;
    #1;
    chk("t4_wr_cnt_after_b", wr_outstanding, 1);
    chk("t4_awready_open", s_awready, 1);
    cyc();
    s_awvalid = 0;
    chk("t4_wr_cnt_third", wr_outstanding, 2);
    chk("t4_m_awvalid_third", m_awvalid, 1);
    chk("t4_awaddr_third", m_awaddr, 32'h108);
    chk("t4_wdata_third", m_wdata, 32'h3);
    cyc();
    m_awready = 0; m_wready = 0;
    m_bvalid = 1; s_bready = 1;
    repeat (2) cyc();
    m_bvalid = 0; s_bready = 0;
    chk("t4_wr_cnt_drain", wr_outstanding, 0);
    chk("t4_err", err_spurious, 0);

    // 5: spurious read response
    m_rvalid = 1; m_rdata = 32'h5555_AAAA; s_rready = 1;
    #1;
    chk("t5_s_rvalid", s_rvalid, 1);
    cyc();
    m_rvalid = 0; s_rready = 0;
    chk("t5_err_set", err_spurious, 1);
    chk("t5_rd_cnt", rd_outstanding, 0);
    repeat (2) cyc();
    chk("t5_err_sticky", err_spurious, 1);

    // 6: reset mid-transaction
    s_awvalid = 1; s_awaddr = 32'h30;
    s_arvalid = 1; s_araddr = 32'h40;
    cyc();
    s_awvalid = 0; s_arvalid = 0;
    chk("t6_m_arvalid", m_arvalid, 1);
    chk("t6_rd_cnt", rd_outstanding, 1);
    chk("t6_wr_cnt", wr_outstanding, 1);
    rst = 1;
    #1;
    chk("t6_rst_arvalid", m_arvalid, 0);
    chk("t6_rst_wready", s_wready, 0);
    chk("t6_rst_arready", s_arready, 0);
    cyc();
    chk("t6_rst_wr_cnt", wr_outstanding, 0);
    chk("t6_rst_rd_cnt", rd_outstanding, 0);
    chk("t6_rst_err", err_spurious, 0);
    rst = 0;
    #1;
    chk("t6_rel_arvalid", m_arvalid, 0);
    chk("t6_rel_awvalid", m_awvalid, 0);
    chk("t6_rel_arready", s_arready, 1);
    s_arvalid = 1; s_araddr = 32'h0;
    cyc();
    s_arvalid = 0;
    chk("t6_rd_arvalid", m_arvalid, 1);
    chk("t6_rd_araddr", m_araddr, 0);
    chk("t6_rd_cnt1", rd_outstanding, 1);
    m_arready = 1;
    cyc();
    m_arready = 0;
    chk("t6_rd_arvalid_done", m_arvalid, 0);
    m_rvalid = 1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b00; s_rready = 1;
    #1;
    chk("t6_s_rdata", s_rdata, 32'hCAFE_F00D);
    chk("t6_s_rresp", s_rresp, 0);
    chk("t6_m_rready", m_rready, 1);
    cyc();
    m_rvalid = 0; s_rready = 0;
    chk("t6_rd_cnt_end", rd_outstanding, 0);
    chk("t6_err_end", err_spurious, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
